// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and ID-stage hazard/stall generation for the 5-stage pipe,
// with one tracked multi-cycle op and a saturating stall-cycle counter.
module fwd_hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_mc,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              mc_issue,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              mc_busy,
  output logic              mc_result_valid,
  output logic [REG_AW-1:0] mc_rd,
  output logic              mc_err,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int CW = $clog2(MC_LAT + 2);

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     effRem;
  logic [REG_AW-1:0] trkRd;
  logic              accept;
  logic              pending;
  logic              mcValid;
  logic              loadUse;
  logic              mcRaw;
  logic              mcWaw;
  logic              mcStruct;

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] x,
    input logic              exW,
    input logic [REG_AW-1:0] exRd,
    input logic              wbW,
    input logic [REG_AW-1:0] wbRd,
    input logic              mcV,
    input logic [REG_AW-1:0] mcRd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (x == '0)
      sel = 2'b00;
    else if (exW && exRd == x)
      sel = 2'b10;
    else if (wbW && wbRd == x)
      sel = 2'b01;
    else if (mcV && mcRd == x)
      sel = 2'b11;
    return sel;
  endfunction

  // An issuing op counts as MC_LAT+1 remaining so it blocks ID this cycle.
  always_comb begin
    accept   = mc_issue & (cnt <= CW'(1));
    effRem   = mc_issue ? CW'(MC_LAT + 1) : cnt;
    trkRd    = mc_issue ? idex_rd : mc_rd;
    pending  = (effRem > CW'(2)) & (trkRd != '0);
    mcValid  = (cnt == CW'(1));
    loadUse  = idex_mem_read & (idex_rd != '0)
             & ((id_uses_rs & (idex_rd == id_rs))
              | (id_uses_rt & (idex_rd == id_rt)));
    mcRaw    = pending
             & ((id_uses_rs & (id_rs == trkRd))
              | (id_uses_rt & (id_rt == trkRd)));
    mcWaw    = pending & id_reg_write & (id_rd == trkRd);
    mcStruct = id_is_mc & (effRem > CW'(2));
  end

  always_comb begin
    forward_a       = 2'b00;
    forward_b       = 2'b00;
    stall           = 1'b0;
    mc_busy         = 1'b0;
    mc_result_valid = 1'b0;
    if (rst_n) begin
      forward_a = fwdSel(idex_rs, exmem_reg_write, exmem_rd,
                         memwb_reg_write, memwb_rd, mcValid, mc_rd);
      forward_b = fwdSel(idex_rt, exmem_reg_write, exmem_rd,
                         memwb_reg_write, memwb_rd, mcValid, mc_rd);
      stall           = id_valid & (loadUse | mcRaw | mcWaw | mcStruct);
      mc_busy         = (cnt != '0);
      mc_result_valid = mcValid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      mc_rd       <= '0;
      mc_err      <= 1'b0;
      stall_count <= '0;
    end else begin
      if (accept) begin
        cnt   <= CW'(MC_LAT);
        mc_rd <= idex_rd;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (mc_issue && !accept)
        mc_err <= 1'b1;
      if (stall && !(&stall_count))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: a behavioural model predicts every output,
// predictions are queued per cycle and drained against the DUT.
module tb_fwd_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 16;
  localparam logic [31:0] CMAX = (32'd1 << CW) - 32'd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_mc;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [AW-1:0] idex_rs, idex_rt, idex_rd;
  logic          idex_mem_read, mc_issue;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [1:0]    forward_a, forward_b;
  logic          stall, mc_busy, mc_result_valid, mc_err;
  logic [AW-1:0] mc_rd;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_rd(id_rd), .id_is_mc(id_is_mc),
    .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .mc_issue(mc_issue),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .mc_busy(mc_busy), .mc_result_valid(mc_result_valid),
    .mc_rd(mc_rd), .mc_err(mc_err), .stall_count(stall_count)
  );

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } sbT;
  sbT sbq[$];

  int          mCnt;
  logic [AW-1:0] mRd;
  logic        mErr;
  logic [31:0] mCount;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dutSig(input int s);
    case (s)
      0: return 32'(forward_a);
      1: return 32'(forward_b);
      2: return 32'(stall);
      3: return 32'(mc_busy);
      4: return 32'(mc_result_valid);
      5: return 32'(mc_rd);
      6: return 32'(mc_err);
      default: return 32'(stall_count);
    endcase
  endfunction

  function automatic string sigName(input int s);
    case (s)
      0: return "fa";
      1: return "fb";
      2: return "stall";
      3: return "busy";
      4: return "valid";
      5: return "mcrd";
      6: return "err";
      default: return "scnt";
    endcase
  endfunction

  function automatic logic [1:0] fwdM(input logic [AW-1:0] x);
    if (!rst_n || x == 0) return 2'b00;
    if (exmem_reg_write && exmem_rd == x) return 2'b10;
    if (memwb_reg_write && memwb_rd == x) return 2'b01;
    if (mCnt == 1 && mRd == x) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic stallM();
    int eff;
    logic [AW-1:0] trk;
    logic pend, lu, raw, waw, st;
    if (!rst_n || !id_valid) return 1'b0;
    eff  = mc_issue ? LAT + 1 : mCnt;
    trk  = mc_issue ? idex_rd : mRd;
    pend = (eff > 2) && (trk != 0);
    lu   = idex_mem_read && idex_rd != 0 &&
           ((id_uses_rs && idex_rd == id_rs) ||
            (id_uses_rt && idex_rd == id_rt));
    raw  = pend && ((id_uses_rs && id_rs == trk) ||
                    (id_uses_rt && id_rt == trk));
    waw  = pend && id_reg_write && id_rd == trk;
    st   = id_is_mc && eff > 2;
    return lu || raw || waw || st;
  endfunction

  task automatic push(input string tag);
    logic [31:0] e [8];
    e[0] = 32'(fwdM(idex_rs));
    e[1] = 32'(fwdM(idex_rt));
    e[2] = 32'(stallM());
    e[3] = 32'(rst_n && mCnt != 0);
    e[4] = 32'(rst_n && mCnt == 1);
    e[5] = 32'(mRd);
    e[6] = 32'(mErr);
    e[7] = mCount;
    for (int i = 0; i < 8; i++) sbq.push_back('{tag, i, e[i]});
  endtask

  task automatic upd();
    logic st, acc;
    st = stallM();
    if (!rst_n) begin
      mCnt = 0; mRd = '0; mErr = 1'b0; mCount = '0;
    end else begin
      acc = mc_issue && (mCnt <= 1);
      if (acc) begin
        mCnt = LAT; mRd = idex_rd;
      end else if (mCnt > 0) begin
        mCnt--;
      end
      if (mc_issue && !acc) mErr = 1'b1;
      if (st && mCount != CMAX) mCount++;
    end
  endtask

  task automatic pre(input string tag);
    push(tag);
    #1;
    while (sbq.size() > 0) begin
      sbT e;
      e = sbq.pop_front();
      chk({e.tag, "/", sigName(e.sig)}, dutSig(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask

  task automatic cyc(input string tag);
    pre(tag);
    tick();
  endtask

  task automatic clrIn();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0;
    id_is_mc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    idex_rs = 0; idex_rt = 0; idex_rd = 0; idex_mem_read = 0;
    mc_issue = 0; exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_rd = 0; memwb_rd = 0;
  endtask

  initial begin
    rst_n = 0;
    clrIn();
    id_valid = 1; id_rs = 3; id_uses_rs = 1;
    idex_mem_read = 1; idex_rd = 3; idex_rs = 3;
    exmem_reg_write = 1; exmem_rd = 3;
    tick();
    cyc("rst0");
    cyc("rst1");
    rst_n = 1;
    clrIn();
    cyc("idle");

    // lw r2 in EX, add r3,r2,r4 in ID
    idex_mem_read = 1; idex_rd = 2;
    id_valid = 1; id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
    id_reg_write = 1; id_rd = 3;
    pre("lu");
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    idex_mem_read = 0; idex_rd = 0;
    exmem_reg_write = 1; exmem_rd = 2;
    cyc("lu_bub");
    exmem_reg_write = 0; exmem_rd = 0;
    memwb_reg_write = 1; memwb_rd = 2;
    id_valid = 0;
    idex_rs = 2; idex_rt = 4; idex_rd = 3;
    pre("lu_fwd");
    chk("lu_fa", 32'(forward_a), 32'd1);
    chk("lu_cnt", 32'(stall_count), 32'd1);
    tick();

    clrIn();
    exmem_reg_write = 1; exmem_rd = 5;
    memwb_reg_write = 1; memwb_rd = 5;
    idex_rs = 5; idex_rt = 5;
    pre("fwd_both");
    chk("fwd_both_fa", 32'(forward_a), 32'd2);
    tick();
    exmem_reg_write = 0;
    cyc("fwd_mw");
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    idex_rs = 0; idex_rt = 0;
    pre("fwd_r0");
    chk("fwd_r0_fa", 32'(forward_a), 32'd0);
    tick();
    for (int i = 0; i < 24; i++) begin
      exmem_reg_write = 1'($urandom_range(0, 1));
      memwb_reg_write = 1'($urandom_range(0, 1));
      exmem_rd = AW'($urandom_range(0, 3));
      memwb_rd = AW'($urandom_range(0, 3));
      idex_rs  = AW'($urandom_range(0, 3));
      idex_rt  = AW'($urandom_range(0, 3));
      cyc("fwd_rnd");
    end

    // MC op rd=7; ID keeps reading r7
    clrIn();
    mc_issue = 1; idex_rd = 7;
    id_valid = 1; id_rs = 7; id_uses_rs = 1;
    pre("mc_t0");
    chk("mc_t0_stall", 32'(stall), 32'd1);
    tick();
    mc_issue = 0; idex_rd = 0;
    cyc("mc_t1");
    pre("mc_t2");
    chk("mc_t2_stall", 32'(stall), 32'd1);
    tick();
    pre("mc_t3");
    chk("mc_t3_stall", 32'(stall), 32'd0);
    tick();
    id_valid = 0; idex_rs = 7;
    pre("mc_t4");
    chk("mc_t4_valid", 32'(mc_result_valid), 32'd1);
    chk("mc_t4_fa", 32'(forward_a), 32'd3);
    tick();
    cyc("mc_t5");

    // reissue accepted at cnt==1, then a rejected issue two cycles later
    clrIn();
    mc_issue = 1; idex_rd = 9;
    cyc("acc_t0");
    mc_issue = 0;
    repeat (3) cyc("acc_wait");
    mc_issue = 1; idex_rd = 10;
    pre("acc1");
    chk("acc1_valid", 32'(mc_result_valid), 32'd1);
    tick();
    chk("acc1_err", 32'(mc_err), 32'd0);
    chk("acc1_rd", 32'(mc_rd), 32'd10);
    mc_issue = 0;
    cyc("rej_gap");
    mc_issue = 1; idex_rd = 11;
    cyc("rej");
    chk("rej_err", 32'(mc_err), 32'd1);
    chk("rej_rd", 32'(mc_rd), 32'd10);
    mc_issue = 0; idex_rd = 0;
    repeat (4) cyc("rej_drain");

    // WAW and structural stalls
    mc_issue = 1; idex_rd = 12;
    cyc("waw_t0");
    mc_issue = 0; idex_rd = 0;
    id_valid = 1; id_reg_write = 1; id_rd = 12;
    pre("waw");
    chk("waw_stall", 32'(stall), 32'd1);
    tick();
    id_reg_write = 0; id_is_mc = 1;
    cyc("struct");
    repeat (3) cyc("struct_drain");

    // reset abandons a pending op
    clrIn();
    mc_issue = 1; idex_rd = 13;
    cyc("rmid_t0");
    mc_issue = 0; idex_rd = 0;
    cyc("rmid_t1");
    rst_n = 0;
    cyc("rmid_rst");
    rst_n = 1;
    id_valid = 1; id_rs = 13; id_uses_rs = 1; idex_rs = 13;
    chk("rmid_busy", 32'(mc_busy), 32'd0);
    chk("rmid_scnt", 32'(stall_count), 32'd0);
    repeat (5) cyc("rmid_after");

    // saturate the stall counter
    clrIn();
    idex_mem_read = 1; idex_rd = 6;
    id_valid = 1; id_rt = 6; id_uses_rt = 1;
    repeat ((1 << CW) + 3) tick();
    pre("sat");
    chk("sat_scnt", 32'(stall_count), CMAX);
    tick();
    cyc("sat_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
